// File: rtl/dac_cfg_seq.sv
// dac_cfg_seq: DAC configuration sequencer and SPI command arbiter.
//   On start, walks an external register table (tbl_idx -> tbl_*), issuing one
//   SPI write per entry through spi_cmd, with optional read-back verify and a
//   bounded number of write+read retries. While no sequence runs, single host
//   read/write requests are passed through to the same spi_cmd engine.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start / busy / done / error  sequence control and status
//   err_index, err_data        failing entry index and its last read-back value
//   tbl_idx -> tbl_addr, tbl_data, tbl_verify, tbl_last   table lookup
//   host_read/host_write/host_addr/host_wdata -> host_ack/host_rdata  host port
//   cmd_read/cmd_write/read_addr/write_addr/write_data,
//   cmd_read_ack/cmd_write_ack/read_data                  spi_cmd interface
module dac_cfg_seq #(
   parameter int TBL_DEPTH = 16,
   parameter int IDX_W     = 4,
   parameter int MAX_RETRY = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [IDX_W-1:0] err_index,
   output logic [7:0]       err_data,
   output logic [IDX_W-1:0] tbl_idx,
   input  logic [15:0]      tbl_addr,
   input  logic [7:0]       tbl_data,
   input  logic             tbl_verify,
   input  logic             tbl_last,
   input  logic             host_read,
   input  logic             host_write,
   input  logic [15:0]      host_addr,
   input  logic [7:0]       host_wdata,
   output logic             host_ack,
   output logic [7:0]       host_rdata,
   output logic             cmd_read,
   output logic             cmd_write,
   input  logic             cmd_read_ack,
   input  logic             cmd_write_ack,
   output logic [15:0]      read_addr,
   output logic [15:0]      write_addr,
   output logic [7:0]       write_data,
   input  logic [7:0]       read_data
);

   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_LATCH, S_WR, S_RD, S_CMP, S_NEXT, S_HOST, S_DONE, S_ERR
   } state_t;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
      logic        verify;
      logic        last;
   } entry_t;

   state_t           state, state_n, ret_state, ret_state_n;
   entry_t           ent, ent_n;
   logic [IDX_W-1:0] idx, idx_n;
   logic [RW-1:0]    retry, retry_n;
   logic [7:0]       rcap, rcap_n;

   logic             busy_n, done_n, error_n, host_ack_n, cmd_read_n, cmd_write_n;
   logic [IDX_W-1:0] err_index_n, tbl_idx_n;
   logic [7:0]       err_data_n, host_rdata_n, write_data_n;
   logic [15:0]      read_addr_n, write_addr_n;

   // Bit 15 is the R/W flag inside spi_cmd; it is never taken from an address.
   logic unused_addr_msb;
   assign unused_addr_msb = &{1'b0, host_addr[15], ent.addr[15]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         ret_state  <= S_IDLE;
         ent        <= '0;
         idx        <= '0;
         retry      <= '0;
         rcap       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         err_index  <= '0;
         err_data   <= '0;
         tbl_idx    <= '0;
         host_ack   <= 1'b0;
         host_rdata <= '0;
         cmd_read   <= 1'b0;
         cmd_write  <= 1'b0;
         read_addr  <= '0;
         write_addr <= '0;
         write_data <= '0;
      end else begin
         state      <= state_n;
         ret_state  <= ret_state_n;
         ent        <= ent_n;
         idx        <= idx_n;
         retry      <= retry_n;
         rcap       <= rcap_n;
         busy       <= busy_n;
         done       <= done_n;
         error      <= error_n;
         err_index  <= err_index_n;
         err_data   <= err_data_n;
         tbl_idx    <= tbl_idx_n;
         host_ack   <= host_ack_n;
         host_rdata <= host_rdata_n;
         cmd_read   <= cmd_read_n;
         cmd_write  <= cmd_write_n;
         read_addr  <= read_addr_n;
         write_addr <= write_addr_n;
         write_data <= write_data_n;
      end
   end

   always_comb begin
      state_n      = state;
      ret_state_n  = ret_state;
      ent_n        = ent;
      idx_n        = idx;
      retry_n      = retry;
      rcap_n       = rcap;
      busy_n       = busy;
      done_n       = done;
      error_n      = error;
      err_index_n  = err_index;
      err_data_n   = err_data;
      tbl_idx_n    = tbl_idx;
      host_ack_n   = 1'b0;
      host_rdata_n = host_rdata;
      cmd_read_n   = cmd_read;
      cmd_write_n  = cmd_write;
      read_addr_n  = read_addr;
      write_addr_n = write_addr;
      write_data_n = write_data;

      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               idx_n   = '0;
               retry_n = '0;
               done_n  = 1'b0;
               error_n = 1'b0;
               busy_n  = 1'b1;
               state_n = S_FETCH;
            end else if ((host_read || host_write) && !host_ack) begin
               // host_ack high means the requester has not yet seen its ack
               // and may still hold the level request; don't serve it twice.
               ret_state_n = state;
               busy_n      = 1'b1;
               state_n     = S_HOST;
               if (host_read) begin
                  cmd_read_n  = 1'b1;
                  read_addr_n = {1'b0, host_addr[14:0]};
               end else begin
                  cmd_write_n  = 1'b1;
                  write_addr_n = {1'b0, host_addr[14:0]};
                  write_data_n = host_wdata;
               end
            end
         end
         S_FETCH: begin
            tbl_idx_n = idx;
            state_n   = S_LATCH;
         end
         S_LATCH: begin
            ent_n   = '{addr: tbl_addr, data: tbl_data, verify: tbl_verify, last: tbl_last};
            state_n = S_WR;
         end
         S_WR: begin
            cmd_write_n  = 1'b1;
            write_addr_n = {1'b0, ent.addr[14:0]};
            write_data_n = ent.data;
            if (cmd_write && cmd_write_ack) begin
               cmd_write_n = 1'b0;
               if (ent.verify) begin
                  // read request rises on the same edge the write drops
                  cmd_read_n  = 1'b1;
                  read_addr_n = {1'b0, ent.addr[14:0]};
                  state_n     = S_RD;
               end else begin
                  state_n = S_NEXT;
               end
            end
         end
         S_RD: begin
            cmd_read_n = 1'b1;
            if (cmd_read && cmd_read_ack) begin
               cmd_read_n = 1'b0;
               rcap_n     = read_data;
               state_n    = S_CMP;
            end
         end
         S_CMP: begin
            if (rcap == ent.data) begin
               state_n = S_NEXT;
            end else if (int'(retry) < MAX_RETRY) begin
               retry_n = retry + RW'(1);
               state_n = S_WR;
            end else begin
               err_index_n = idx;
               err_data_n  = rcap;
               error_n     = 1'b1;
               busy_n      = 1'b0;
               state_n     = S_ERR;
            end
         end
         S_NEXT: begin
            if (ent.last || idx == IDX_W'(TBL_DEPTH - 1)) begin
               done_n  = 1'b1;
               busy_n  = 1'b0;
               state_n = S_DONE;
            end else begin
               idx_n   = idx + IDX_W'(1);
               retry_n = '0;
               state_n = S_FETCH;
            end
         end
         S_HOST: begin
            if (cmd_read && cmd_read_ack) begin
               cmd_read_n   = 1'b0;
               host_rdata_n = read_data;
               host_ack_n   = 1'b1;
               busy_n       = 1'b0;
               state_n      = ret_state;
            end else if (cmd_write && cmd_write_ack) begin
               cmd_write_n = 1'b0;
               host_ack_n  = 1'b1;
               busy_n      = 1'b0;
               state_n     = ret_state;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_dac_cfg_seq.sv
module tb_dac_cfg_seq;

   logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic        busy, done, error, host_ack, cmd_read, cmd_write;
   logic [3:0]  err_index, tbl_idx;
   logic [7:0]  err_data, host_rdata, write_data, tbl_data;
   logic [15:0] read_addr, write_addr, tbl_addr;
   logic        tbl_verify, tbl_last;
   logic        host_read = 1'b0, host_write = 1'b0;
   logic [15:0] host_addr = '0;
   logic [7:0]  host_wdata = '0;
   logic        cmd_read_ack, cmd_write_ack;
   logic [7:0]  read_data;

   always #5 clk = ~clk;

   // register table
   logic [15:0] tbl_a [16];
   logic [7:0]  tbl_d [16];
   logic        tbl_v [16];
   logic        tbl_l [16];
   assign tbl_addr   = tbl_a[tbl_idx];
   assign tbl_data   = tbl_d[tbl_idx];
   assign tbl_verify = tbl_v[tbl_idx];
   assign tbl_last   = tbl_l[tbl_idx];

   dac_cfg_seq dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
      .err_index(err_index), .err_data(err_data), .tbl_idx(tbl_idx),
      .tbl_addr(tbl_addr), .tbl_data(tbl_data), .tbl_verify(tbl_verify), .tbl_last(tbl_last),
      .host_read(host_read), .host_write(host_write), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
      .cmd_read(cmd_read), .cmd_write(cmd_write), .cmd_read_ack(cmd_read_ack),
      .cmd_write_ack(cmd_write_ack), .read_addr(read_addr), .write_addr(write_addr),
      .write_data(write_data), .read_data(read_data)
   );

   // spi_cmd stub: acks a request after 3 cycles, once per request.
   // Reads echo the last written byte unless forced or set to fail.
   logic        stub_clr = 1'b0;
   logic [15:0] fail_addr = '0;
   int          fail_cnt = 0;
   logic [7:0]  bad_val = '0;
   logic        rf_en = 1'b0;
   logic [7:0]  rf_val = '0;
   int          wr_cnt, rd_cnt, fcnt, cw, cr;
   logic        lock_w, lock_r, first_seen;
   logic [15:0] first_wa, last_wa, last_ra;
   logic [7:0]  last_wd;

   always @(posedge clk) begin
      cmd_write_ack <= 1'b0;
      cmd_read_ack  <= 1'b0;
      if (rst || stub_clr) begin
         lock_w <= 1'b0; lock_r <= 1'b0; cw <= 0; cr <= 0;
         if (stub_clr) begin
            wr_cnt <= 0; rd_cnt <= 0; fcnt <= 0; first_seen <= 1'b0;
            first_wa <= '0; last_wa <= '0; last_ra <= '0; last_wd <= '0; read_data <= '0;
         end
      end else begin
         if (!cmd_write) lock_w <= 1'b0;
         if (!cmd_read)  lock_r <= 1'b0;
         if (cmd_write && !lock_w) begin
            if (cw == 2) begin
               cmd_write_ack <= 1'b1; lock_w <= 1'b1; cw <= 0;
               wr_cnt <= wr_cnt + 1; last_wa <= write_addr; last_wd <= write_data;
               if (!first_seen) begin first_seen <= 1'b1; first_wa <= write_addr; end
            end else cw <= cw + 1;
         end
         if (cmd_read && !lock_r) begin
            if (cr == 2) begin
               cmd_read_ack <= 1'b1; lock_r <= 1'b1; cr <= 0;
               rd_cnt <= rd_cnt + 1; last_ra <= read_addr;
               if (rf_en) read_data <= rf_val;
               else if (read_addr == fail_addr && fcnt < fail_cnt) read_data <= bad_val;
               else read_data <= last_wd;
               if (read_addr == fail_addr) fcnt <= fcnt + 1;
            end else cr <= cr + 1;
         end
      end
   end

   int n_vec = 0, n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [15:0] a0;      // entry 0 address
      logic [7:0]  d0;      // entry 0 data
      int          last;    // index carrying tbl_last, -1 = none
      logic        ver;     // verify flag on every entry
      logic [15:0] fa;      // read address that returns bad_val
      int          fc;      // how many reads of fa return bad_val
      logic [7:0]  bad;
      int          ewr, erd;
      logic        edone, eerr;
      logic [3:0]  eidx;
      logic [7:0]  edata;
      logic [15:0] efirst;
      logic [7:0]  elastwd;
   } vec_t;

   task automatic load_tbl(input logic [15:0] a0, input logic [7:0] d0, input int last, input logic ver);
      for (int i = 0; i < 16; i++) begin
         tbl_a[i] = (i == 0) ? a0 : 16'((i + 1) * 16);
         tbl_d[i] = (i == 0) ? d0 : 8'((i + 1) * 17);
         tbl_v[i] = ver;
         tbl_l[i] = (i == last);
      end
   endtask

   task automatic clr_stub();
      @(negedge clk) stub_clr = 1'b1;
      @(negedge clk) stub_clr = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy && n < 5000) begin @(negedge clk); n++; end
      if (busy) chk({nm, " idle timeout"}, 32'(busy), 32'd0);
   endtask

   task automatic wait_hack(input string nm);
      int n = 0;
      while (!host_ack && n < 5000) begin @(negedge clk); n++; end
      if (!host_ack) chk({nm, " host_ack timeout"}, 32'(host_ack), 32'd1);
   endtask

   vec_t v [6];

   initial begin
      v[0] = '{16'h0010, 8'h11,  2, 1'b0, 16'hFFFF, 0,  8'h00,  3,  0, 1'b1, 1'b0, 4'd0, 8'h00, 16'h0010, 8'h33};
      v[1] = '{16'h0012, 8'hA5,  0, 1'b1, 16'hFFFF, 0,  8'h00,  1,  1, 1'b1, 1'b0, 4'd0, 8'h00, 16'h0012, 8'hA5};
      v[2] = '{16'h0012, 8'hA5, -1, 1'b1, 16'hFFFF, 0,  8'h00, 16, 16, 1'b1, 1'b0, 4'd0, 8'h00, 16'h0012, 8'h10};
      v[3] = '{16'h0012, 8'hA5,  0, 1'b1, 16'h0012, 99, 8'h00,  4,  4, 1'b0, 1'b1, 4'd0, 8'h00, 16'h0012, 8'hA5};
      v[4] = '{16'h0012, 8'h5A,  0, 1'b1, 16'h0012, 1,  8'h00,  2,  2, 1'b1, 1'b0, 4'd0, 8'h00, 16'h0012, 8'h5A};
      v[5] = '{16'h8010, 8'h11,  2, 1'b1, 16'h0030, 99, 8'hC3,  6,  6, 1'b0, 1'b1, 4'd2, 8'hC3, 16'h0010, 8'h33};
      load_tbl(16'h0010, 8'h11, 2, 1'b0);

      // reset state
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst busy", 32'(busy), 0);
      chk("rst done", 32'(done), 0);
      chk("rst error", 32'(error), 0);
      chk("rst cmd", {30'd0, cmd_read, cmd_write}, 0);
      chk("rst host_ack", 32'(host_ack), 0);
      chk("rst addr", {write_addr, read_addr}, 0);

      // table-driven sequences
      for (int k = 0; k < 6; k++) begin
         string p;
         p = $sformatf("v%0d", k);
         load_tbl(v[k].a0, v[k].d0, v[k].last, v[k].ver);
         fail_addr = v[k].fa; fail_cnt = v[k].fc; bad_val = v[k].bad;
         clr_stub();
         pulse_start();
         chk({p, " busy"}, 32'(busy), 1);
         wait_idle(p);
         chk({p, " wr_cnt"}, wr_cnt, v[k].ewr);
         chk({p, " rd_cnt"}, rd_cnt, v[k].erd);
         chk({p, " done"}, 32'(done), 32'(v[k].edone));
         chk({p, " error"}, 32'(error), 32'(v[k].eerr));
         if (v[k].eerr) begin
            chk({p, " err_index"}, 32'(err_index), 32'(v[k].eidx));
            chk({p, " err_data"}, 32'(err_data), 32'(v[k].edata));
         end
         chk({p, " first waddr"}, 32'(first_wa), 32'(v[k].efirst));
         chk({p, " last wdata"}, 32'(last_wd), 32'(v[k].elastwd));
         chk({p, " cmd idle"}, {30'd0, cmd_read, cmd_write}, 0);
      end

      // start and host write in the same cycle: sequence first
      load_tbl(16'h0010, 8'h11, 2, 1'b0);
      fail_cnt = 0;
      clr_stub();
      host_addr = 16'h0003; host_wdata = 8'h7F; host_write = 1'b1;
      pulse_start();
      chk("arb seq first", {30'd0, busy, cmd_write}, 32'b10);
      begin
         int n = 0;
         int early = 0;
         while (!done && n < 5000) begin
            if (host_ack) early++;
            @(negedge clk); n++;
         end
         chk("arb done", 32'(done), 1);
         chk("arb no early ack", early, 0);
         chk("arb seq writes", wr_cnt, 3);
      end
      wait_hack("arb");
      host_write = 1'b0;
      chk("arb host wr_cnt", wr_cnt, 4);
      chk("arb host waddr", 32'(last_wa), 32'h0003);
      chk("arb host wdata", 32'(last_wd), 32'h7F);
      @(negedge clk);
      chk("arb ack one cycle", 32'(host_ack), 0);
      repeat (4) @(negedge clk);
      chk("arb no repeat", wr_cnt, 4);

      // host read after sequence: done preserved
      rf_en = 1'b1; rf_val = 8'h3C;
      host_addr = 16'h1234; host_read = 1'b1;
      wait_hack("hrd");
      host_read = 1'b0;
      chk("hrd rdata", 32'(host_rdata), 32'h3C);
      chk("hrd raddr", 32'(last_ra), 32'h1234);
      chk("hrd done", 32'(done), 1);
      @(negedge clk);
      chk("hrd rdata held", 32'(host_rdata), 32'h3C);
      chk("hrd busy", 32'(busy), 0);
      rf_en = 1'b0;

      // reset in the middle of a write, then restart latency
      load_tbl(16'h0010, 8'h11, 2, 1'b0);
      clr_stub();
      pulse_start();
      begin
         int n = 0;
         while (!cmd_write && n < 100) begin @(negedge clk); n++; end
         chk("rw reached WR", 32'(cmd_write), 1);
      end
      rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      chk("rw cmd after rst", {30'd0, cmd_read, cmd_write}, 0);
      chk("rw busy after rst", 32'(busy), 0);
      chk("rw wdata after rst", {write_addr, 8'd0, write_data}, 0);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("rw lat e0", 32'(cmd_write), 0);
      @(negedge clk);
      chk("rw lat e1", 32'(cmd_write), 0);
      @(negedge clk);
      chk("rw lat e2", 32'(cmd_write), 0);
      @(negedge clk);
      chk("rw lat e3", 32'(cmd_write), 1);
      chk("rw restart addr", {write_addr, 8'd0, write_data}, {16'h0010, 16'h0011});
      wait_idle("rw");
      chk("rw done", 32'(done), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dac_cfg_seq.md
# dac_cfg_seq

Configuration sequencer and access arbiter in front of `spi_cmd`. On `start`, it walks an external register table and issues one SPI write per entry to the DAC. Entries flagged for verification get a read-back compare, with a bounded number of retries. When no sequence is running, it also passes single host read/write requests through to `spi_cmd`, so the host and the init sequence share one SPI command engine.

## Interface
- `TBL_DEPTH`, 16, number of table entries; the sequence never indexes beyond `TBL_DEPTH-1`.
- `IDX_W`, 4, width of the table index; must satisfy `2^IDX_W >= TBL_DEPTH`.
- `MAX_RETRY`, 3, extra write+read attempts allowed after a failed verify (0 = no retry).
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, synchronous and active-high; all registers clear on the first `clk` edge where `rst`=1.
- `start` in 1: one-cycle pulse that begins a sequence; ignored while `busy`=1.
- `busy` out 1: a sequence or host access is in progress.
- `done` out 1: level; last sequence completed cleanly; cleared by `start`.
- `error` out 1: level; verify failed after retries; cleared by `start`.
- `err_index` out `IDX_W`: index of the failing entry.
- `err_data` out 8: last read-back value of the failing entry.
- `tbl_idx` out `IDX_W`: table lookup index.
- `tbl_addr` in 16, `tbl_data` in 8, `tbl_verify` in 1, `tbl_last` in 1: combinational table contents for `tbl_idx`.
- `host_read` in 1, `host_write` in 1: level requests, held until `host_ack`; read has priority if both are high.
- `host_addr` in 16, `host_wdata` in 8: host access fields, stable while the request is held.
- `host_ack` out 1: one-cycle completion pulse.
- `host_rdata` out 8: read result, valid from the `host_ack` cycle until the next host read.
- `cmd_read` out 1, `cmd_write` out 1: requests to `spi_cmd`; at most one is high at a time.
- `cmd_read_ack` in 1, `cmd_write_ack` in 1: one-cycle acks from `spi_cmd`.
- `read_addr` out 16, `write_addr` out 16, `write_data` out 8: command fields to `spi_cmd`.
- `read_data` in 8: valid in the ack cycle.

## Operation
- States: IDLE, FETCH, LATCH, WR, RD, CMP, NEXT, HOST, DONE, ERR. DONE and ERR behave as IDLE for arbitration.
- **Reset values.** All outputs reset to 0; state resets to IDLE.
- **Address bit 15.** Bit 15 is the R/W flag in `spi_cmd`, so `read_addr[15]` and `write_addr[15]` are forced to 0; the sequencer drives only bits 14:0.
- **Entering a sequence.** From IDLE/DONE/ERR, `start`=1 sets idx=0, retry=0, `done`=0, `error`=0, `busy`=1, then goes to FETCH.
- **FETCH.** `tbl_idx`=idx, then go to LATCH.
- **LATCH.** Register `tbl_addr`, `tbl_data`, `tbl_verify`, `tbl_last`, then go to WR.
- **WR.** `cmd_write`=1 with the latched addr/data, held until `cmd_write_ack` is sampled. Then go to RD if verify=1, else NEXT.
- **RD.** `cmd_read`=1 with `read_addr`=latched addr, held until `cmd_read_ack`. Capture `read_data` in the ack cycle, then go to CMP.
- **CMP.**
  - Match: go to NEXT.
  - Mismatch with retry<`MAX_RETRY`: retry+1, go to WR.
  - Mismatch with retry=`MAX_RETRY`: go to ERR, with `err_index`=idx and `err_data`=captured value.
- **NEXT.**
  - If latched last=1 or idx=`TBL_DEPTH-1`: go to DONE, `done`=1, `busy`=0.
  - Otherwise: idx+1, retry=0, go to FETCH. idx never wraps.
- **ERR.** `error`=1, `busy`=0. No further SPI traffic until `start` or a host request.
- **Host access.** From IDLE/DONE/ERR with a host request (read has priority) and `start`=0, go to HOST with `busy`=1.
  - Issue `cmd_read` or `cmd_write` using `host_*` fields.
  - On ack: pulse `host_ack`, load `host_rdata` on reads, return to the prior idle-class state. `done`/`error` are preserved.
- **Arbitration.** If `start` and a host request arrive in the same cycle, `start` wins; the host request stays pending and is served after the sequence ends.
- **`start` while busy.** Ignored; no queuing.
- **`rst` mid-transfer.** The block returns to IDLE on the next edge with `cmd_*`=0. `spi_cmd` shares `rst`, so no orphaned transaction remains.

## Timing
- `cmd_read`, `cmd_write`, and all address/data outputs are registered.
- **Start latency.** `start` sampled at edge 0 → FETCH at edge 1, LATCH at edge 2 → `cmd_write`=1 and fields valid from edge 3.
- **Request drop.** `cmd_*` drop to 0 on the edge after the ack cycle. The ack is one cycle and `spi_cmd` then spends at least 256 cycles in CE_HIGH, so no duplicate command is issued.
- **Back-to-back commands.**
  - WR→RD: `cmd_read` rises on the same edge `cmd_write` falls.
  - CMP→WR retry: adds 1 cycle.
  - NEXT→FETCH→LATCH→WR: adds 3 cycles between entries.
- **Host path.** A host request sampled in an idle-class state → `cmd_*` high on the next edge. `host_ack` is high exactly the cycle after the SPI ack.
- **Status flags.** `done`/`error` assert on the same edge `busy` falls.

## Test plan
- **Plain writes.** 3-entry table (0x0010/0x11, 0x0020/0x22, 0x0030/0x33, `tbl_last` at idx 2), verify=0 → three writes in order, no `cmd_read`; `done`=1, `busy`=0, `error`=0.
- **Verify pass / depth limit.**
  - Entry 0x0012/0xA5, verify=1, stub returns 0xA5 → one write, one read, `done`=1.
  - Same table with no `tbl_last` set → exactly `TBL_DEPTH` entries processed, then `done`=1.
- **Verify fail.** Stub always returns 0x00, `MAX_RETRY`=3 → 4 writes and 4 reads; `error`=1, `err_index`=0, `err_data`=0x00, `done`=0.
- **Retry success.** First read returns 0x00, second returns 0x5A for data 0x5A → 2 writes, 2 reads, `done`=1.
- **Arbitration.** `start` and `host_write` (0x0003/0x7F) in the same cycle → sequence completes first, then one host write and a single-cycle `host_ack`. A subsequent `host_read` with stub 0x3C gives `host_rdata`=0x3C; `done` stays 1.
- **Reset mid-WR.** `rst`=1 for one cycle → next edge has all outputs 0 and state IDLE. A new `start` restarts at idx 0 with `cmd_write` 3 cycles later.
